dct_coef_engine: RTL

//  Sequential, parametrised successor to the per-(k1,k2) DCT cosine LUTs. For any
//  run-time (k1,k2), accepts one NxN pixel block in raster order over a valid/ready

---
 rtl/dct_pkg.sv | 51 +++++
 rtl/dct_cos_rom.sv | 27 ++
 rtl/dct_coef_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared types and the elaboration-time cosine table builder for the DCT coefficient engine.
package dct_pkg;

  localparam int N      = 8;
  localparam int FRAC_W = 8;
  localparam int K_W    = $clog2(N);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  // c(k,n) = cos(k*(2n+1)*pi/(2*nd)) scaled by 2^fw. The phase is folded into the first
  // quadrant, the cosine is evaluated with an integer Taylor series in Q30, and the magnitude
  // is truncated toward zero so the table reproduces the legacy LUT contents
  // (e.g. k=7,n=0 -> 0x031).
  function automatic int cos_q(input int k, input int n, input int nd = N, input int fw = FRAC_W);
    longint pi_q;
    longint x;
    longint term;
    longint sum;
    int     m;
    int     mr;
    int     mag;
    logic   neg;
    pi_q = 64'sd3373259426;
    m    = (k * (2 * n + 1)) % (4 * nd);
    if (m <= nd) begin
      mr  = m;
      neg = 1'b0;
    end else if (m <= 2 * nd) begin
      mr  = 2 * nd - m;
      neg = 1'b1;
    end else if (m <= 3 * nd) begin
      mr  = m - 2 * nd;
      neg = 1'b1;
    end else begin
      mr  = 4 * nd - m;
      neg = 1'b0;
    end
    x    = (longint'(mr) * pi_q) / longint'(2 * nd);
    term = 64'sd1073741824;
    sum  = term;
    for (int unsigned i = 1; i <= 12; i++) begin
      term = (((term * x) >>> 30) * x) >>> 30;
      term = -(term / longint'((2 * i - 1) * (2 * i)));
      sum  = sum + term;
    end
    if (sum < 0) mag = 0;
    else         mag = int'(sum >>> (30 - fw));
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/dct_cos_rom.sv
// Combinational (k,n) -> c(k,n) lookup; contents are fixed at elaboration from dct_pkg::cos_q.
module dct_cos_rom
  import dct_pkg::*;
#(
  parameter int  N      = 8,
  parameter int  FRAC_W = 8,
  localparam int K_W    = $clog2(N),
  localparam int C_W    = FRAC_W + 2
) (
  input  logic [K_W-1:0]        k,
  input  logic [K_W-1:0]        n,
  output logic signed [C_W-1:0] c
);

  logic signed [C_W-1:0] rom_tbl [N*N];

  for (genvar gk = 0; gk < N; gk++) begin : g_k
    for (genvar gn = 0; gn < N; gn++) begin : g_n
      localparam int V = cos_q(gk, gn, N, FRAC_W);
      assign rom_tbl[gk*N+gn] = C_W'(V);
    end
  end

  // N is a power of two, so {k,n} addresses the table densely.
  always_comb c = rom_tbl[{k, n}];

endmodule

// File: rtl/dct_coef_engine.sv
// Sequential DCT coefficient engine: one NxN block in, one X[k1][k2] out (no alpha scaling).
module dct_coef_engine
  import dct_pkg::*;
#(
  parameter int  N      = 8,
  parameter int  DATA_W = 8,
  parameter int  FRAC_W = 8,
  parameter int  OUT_W  = 32,
  localparam int K_W    = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [K_W-1:0]           k1,
  input  logic [K_W-1:0]           k2,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic signed [DATA_W-1:0] pix_data,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic signed [OUT_W-1:0]  coef_data,
  output logic                     busy
);

  localparam int C_W   = FRAC_W + 2;
  localparam int M_W   = 2 * C_W;
  localparam int P_W   = DATA_W + FRAC_W + 2;
  localparam int ACC_W = DATA_W + FRAC_W + 2 * K_W + 2;

  state_t                    state_q, state_d;
  logic [K_W-1:0]            k1_q, k1_d, k2_q, k2_d;
  logic [K_W-1:0]            n1_q, n1_d, n2_q, n2_d;
  logic signed [P_W-1:0]     prod_q, prod_d;
  logic                      prod_vld_q, prod_vld_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [OUT_W-1:0]   coef_q, coef_d;

  logic signed [C_W-1:0]     c_row, c_col;
  logic signed [M_W-1:0]     cc_full;
  logic signed [C_W-1:0]     cos2d;
  logic signed [P_W-1:0]     prod_now;
  logic signed [OUT_W-1:0]   acc_out;
  logic                      accept;
  logic                      last_pix;
  logic                      unused_bits;

  dct_cos_rom #(.N(N), .FRAC_W(FRAC_W)) u_rom_row (.k(k1_q), .n(n1_q), .c(c_row));
  dct_cos_rom #(.N(N), .FRAC_W(FRAC_W)) u_rom_col (.k(k2_q), .n(n2_q), .c(c_col));

  // Product path: 2-D cosine (floor shift) times the current pixel.
  // |c| <= 2^FRAC_W, so the shifted product always fits in C_W bits.
  always_comb begin
    cc_full  = M_W'(c_row) * M_W'(c_col);
    cos2d    = cc_full[FRAC_W +: C_W];
    prod_now = P_W'(pix_data) * P_W'(cos2d);
  end

  // Low fraction bits and the redundant sign bits of the 2-D product are discarded.
  always_comb unused_bits = ^{cc_full[M_W-1:FRAC_W+C_W], cc_full[FRAC_W-1:0]};

  if (ACC_W > OUT_W) begin : g_sat
    // Clamp to the signed output range when the accumulator exceeds it.
    always_comb begin
      acc_out = OUT_W'(acc_q);
      if (!acc_q[ACC_W-1] && (|acc_q[ACC_W-2:OUT_W-1]))
        acc_out = {1'b0, {(OUT_W-1){1'b1}}};
      else if (acc_q[ACC_W-1] && !(&acc_q[ACC_W-2:OUT_W-1]))
        acc_out = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end else begin : g_ext
    // Sign-extend the accumulator to the output width.
    always_comb acc_out = OUT_W'(acc_q);
  end

  // Next-state, counters, pipeline stages and result capture.
  always_comb begin
    state_d    = state_q;
    k1_d       = k1_q;
    k2_d       = k2_q;
    n1_d       = n1_q;
    n2_d       = n2_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = acc_q;
    coef_d     = coef_q;
    accept     = (state_q == ACCUM) && pix_valid;
    last_pix   = (n1_q == '1) && (n2_q == '1);

    if (accept) begin
      prod_d     = prod_now;
      prod_vld_d = 1'b1;
    end
    if (prod_vld_q) acc_d = acc_q + ACC_W'(prod_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          k1_d    = k1;
          k2_d    = k2;
          n1_d    = '0;
          n2_d    = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (last_pix) state_d = DRAIN;
          n2_d = n2_q + 1'b1;
          if (n2_q == '1) n1_d = n1_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!prod_vld_q) begin
          state_d = DONE;
          coef_d  = acc_out;
        end
      end
      DONE: begin
        if (coef_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state and the captured result.
  always_comb begin
    pix_ready  = (state_q == ACCUM);
    coef_valid = (state_q == DONE);
    busy       = (state_q != IDLE);
    coef_data  = coef_q;
  end

  // State register with synchronous, dominant reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k1_q       <= '0;
      k2_q       <= '0;
      n1_q       <= '0;
      n2_q       <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      coef_q     <= '0;
    end else begin
      state_q    <= state_d;
      k1_q       <= k1_d;
      k2_q       <= k2_d;
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      coef_q     <= coef_d;
    end
  end

endmodule
